switch_box_cfg_loader: RTL and testbench

SWITCH_BOX_CFG_LOADER -- requirements
Module: switch_box_cfg_loader

---
 rtl/sb_cfg_defs.sv | 21 ++
 rtl/switch_box_cfg_loader.sv | 145 ++++++++++++++
 tb/tb_switch_box_cfg_loader.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sb_cfg_defs.sv
// Shared switch-box configuration definitions: config/payload sizing and loader state encoding.
// Used by the loader, by clb_switch_box, and by their benches.
package sb_cfg_defs;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        WAIT  = 2'd3
    } sb_state_t;

    // Each single-wire track contributes 8 switch points per side set; doubles pair up.
    function automatic int sb_cw(input int ws, input int wd);
        return ws * 8 + (wd / 2) * 8;
    endfunction

    function automatic int sb_nw(input int cw, input int dw);
        return (cw + dw - 1) / dw;
    endfunction

endpackage

// File: rtl/switch_box_cfg_loader.sv
// Loads a checksummed bitstream into a shadow register and commits it to c on cset.
// One word per cfg_valid&cfg_ready cycle; cfg_ready is registered, high only in LOAD/CHECK.
module switch_box_cfg_loader
    import sb_cfg_defs::*;
#(
    parameter int WS = 7,
    parameter int WD = 6,
    parameter int DW = 8,
    localparam int CW = sb_cw(WS, WD),
    localparam int NW = sb_nw(CW, DW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_start,
    input  logic          cfg_valid,
    input  logic [DW-1:0] cfg_data,
    output logic          cfg_ready,
    input  logic          cset,
    output logic [CW-1:0] c,
    output logic          loaded,
    output logic          err
);

    localparam int CNT_W = $clog2(NW + 1);

    sb_state_t          state;
    sb_state_t          state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [DW-1:0]      xor_acc;
    logic [CW-1:0]      shadow;
    logic [CW-1:0]      shadow_nxt;
    logic [NW*DW-1:0]   shadow_wide;

    logic               xfer;
    logic               last_word;
    logic               sum_ok;
    logic               wr_word;
    logic               chk_fail;
    logic               commit;

    assign xfer      = cfg_valid & cfg_ready;
    assign last_word = (cnt == CNT_W'(NW - 1));
    assign sum_ok    = (cfg_data == xor_acc);

    // cfg_start always wins: it restarts from any state and masks transfers and commits.
    always_comb begin
        state_nxt = state;
        wr_word   = 1'b0;
        chk_fail  = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (cfg_start) begin
                    state_nxt = LOAD;
                end else if (xfer) begin
                    wr_word = 1'b1;
                    if (last_word) begin
                        state_nxt = CHECK;
                    end
                end
            end
            CHECK: begin
                if (cfg_start) begin
                    state_nxt = LOAD;
                end else if (xfer) begin
                    if (sum_ok) begin
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = IDLE;
                        chk_fail  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cfg_start) begin
                    state_nxt = LOAD;
                end else if (cset) begin
                    state_nxt = IDLE;
                    commit    = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Padded view so the last word may overhang CW; bits beyond CW are dropped.
    always_comb begin
        shadow_wide = (NW * DW)'(shadow);
        for (int k = 0; k < NW; k++) begin
            if (cnt == CNT_W'(k)) begin
                shadow_wide[k*DW +: DW] = cfg_data;
            end
        end
        shadow_nxt = shadow_wide[CW-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_ready <= 1'b0;
            loaded    <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
            xor_acc   <= '0;
            shadow    <= '0;
            c         <= '0;
        end else begin
            cfg_ready <= (state_nxt == LOAD) || (state_nxt == CHECK);
            loaded    <= (state_nxt == WAIT);
            if (cfg_start) begin
                cnt     <= '0;
                xor_acc <= '0;
                err     <= 1'b0;
                shadow  <= '0;
            end else begin
                if (wr_word) begin
                    shadow  <= shadow_nxt;
                    xor_acc <= xor_acc ^ cfg_data;
                    cnt     <= cnt + CNT_W'(1);
                end
                if (chk_fail) begin
                    err <= 1'b1;
                end
                if (commit) begin
                    c <= shadow;
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_box_cfg_loader.sv
// Bench for switch_box_cfg_loader: directed scenarios plus randomized loads against a payload-level model.
module tb_switch_box_cfg_loader;
    import sb_cfg_defs::*;

    localparam int DW = 8;
    localparam int CW = sb_cw(7, 6);
    localparam int NW = sb_nw(CW, DW);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_start = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [DW-1:0] cfg_data = '0;
    logic          cfg_ready;
    logic          cset = 1'b0;
    logic [CW-1:0] c;
    logic          loaded;
    logic          err;

    int n_vec = 0;
    int n_miss = 0;

    logic [DW-1:0] pay [NW];
    logic [CW-1:0] exp_c = '0;
    logic [CW-1:0] ref_c;

    switch_box_cfg_loader dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .cset      (cset),
        .c         (c),
        .loaded    (loaded),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: the image is the payload words laid end to end, word 0 in the LSBs.
    function automatic logic [CW-1:0] image_of();
        logic [NW*DW-1:0] w;
        w = '0;
        for (int k = 0; k < NW; k++) w[k*DW +: DW] = pay[k];
        return w[CW-1:0];
    endfunction

    function automatic logic [DW-1:0] sum_of();
        logic [DW-1:0] s;
        s = '0;
        for (int k = 0; k < NW; k++) s = s ^ pay[k];
        return s;
    endfunction

    // All tasks are entered and left just after a falling edge.
    task automatic pulse_start();
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic pulse_cset();
        cset = 1'b1;
        @(negedge clk);
        cset = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] w, input int stall);
        int n;
        cfg_valid = 1'b0;
        repeat (stall) @(negedge clk);
        cfg_data  = w;
        cfg_valid = 1'b1;
        n = 0;
        while (cfg_ready !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (cfg_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL word_accept: cfg_ready=%b required 1 for data %h", cfg_ready, w);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic send_payload(input logic [DW-1:0] chk, input int stall);
        for (int k = 0; k < NW; k++) send_word(pay[k], stall);
        send_word(chk, stall);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (c !== '0 || loaded !== 1'b0 || err !== 1'b0 || cfg_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_state: c=%h loaded=%b err=%b rdy=%b required all zero", c, loaded, err, cfg_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (cfg_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_idle_rdy: cfg_ready=%b required 0", cfg_ready);
        end
    endtask

    task automatic test_basic_load();
        for (int k = 0; k < NW; k++) pay[k] = DW'(k + 1);
        pulse_start();
        send_payload(8'h0B, 0);
        n_vec++;
        if (loaded !== 1'b1 || err !== 1'b0 || c !== exp_c || cfg_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL basic_wait: loaded=%b err=%b c=%h rdy=%b required 1 0 %h 0", loaded, err, c, cfg_ready, exp_c);
        end
        pulse_cset();
        exp_c = 80'h0A090807060504030201;
        n_vec++;
        if (c !== exp_c || loaded !== 1'b0 || err !== 1'b0) begin
            n_miss++;
            $display("FAIL basic_commit: c=%h loaded=%b err=%b required %h 0 0", c, loaded, err, exp_c);
        end
    endtask

    task automatic test_bad_checksum();
        for (int k = 0; k < NW; k++) pay[k] = DW'(k + 1);
        pulse_start();
        send_payload(8'h00, 0);
        n_vec++;
        if (err !== 1'b1 || loaded !== 1'b0 || c !== exp_c) begin
            n_miss++;
            $display("FAIL bad_sum: err=%b loaded=%b c=%h required 1 0 %h", err, loaded, c, exp_c);
        end
        pulse_cset();
        repeat (2) @(negedge clk);
        n_vec++;
        if (c !== exp_c || err !== 1'b1) begin
            n_miss++;
            $display("FAIL bad_sum_cset_idle: c=%h err=%b required %h 1", c, err, exp_c);
        end
    endtask

    task automatic test_abort();
        for (int k = 0; k < NW; k++) pay[k] = DW'(8'h40 + k);
        pulse_start();
        n_vec++;
        if (err !== 1'b0) begin
            n_miss++;
            $display("FAIL start_clears_err: err=%b required 0", err);
        end
        for (int k = 0; k < 5; k++) send_word(pay[k], 0);
        pulse_start();
        for (int k = 0; k < NW; k++) pay[k] = 8'hFF;
        send_payload(8'h00, 0);
        n_vec++;
        if (loaded !== 1'b1 || c !== exp_c) begin
            n_miss++;
            $display("FAIL abort_wait: loaded=%b c=%h required 1 %h", loaded, c, exp_c);
        end
        pulse_cset();
        exp_c = '1;
        n_vec++;
        if (c !== exp_c || err !== 1'b0) begin
            n_miss++;
            $display("FAIL abort_commit: c=%h err=%b required %h 0", c, err, exp_c);
        end
    endtask

    task automatic test_stalled();
        for (int k = 0; k < NW; k++) pay[k] = DW'(k + 1);
        pulse_start();
        send_payload(8'h0B, 3);
        pulse_cset();
        exp_c = 80'h0A090807060504030201;
        n_vec++;
        if (c !== exp_c || loaded !== 1'b0 || err !== 1'b0) begin
            n_miss++;
            $display("FAIL stalled_commit: c=%h loaded=%b err=%b required %h 0 0", c, loaded, err, exp_c);
        end
    endtask

    task automatic test_cset_outside_wait();
        for (int k = 0; k < NW; k++) pay[k] = DW'($urandom);
        pulse_start();
        cset = 1'b1;
        for (int k = 0; k < NW; k++) send_word(pay[k], 0);
        @(negedge clk);
        n_vec++;
        if (c !== exp_c || loaded !== 1'b0 || cfg_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL cset_in_load_check: c=%h loaded=%b rdy=%b required %h 0 1", c, loaded, cfg_ready, exp_c);
        end
        cset = 1'b0;
        send_word(sum_of(), 0);
        n_vec++;
        if (c !== exp_c || loaded !== 1'b1) begin
            n_miss++;
            $display("FAIL cset_wait_hold: c=%h loaded=%b required %h 1", c, loaded, exp_c);
        end
        pulse_cset();
        exp_c = image_of();
        n_vec++;
        if (c !== exp_c) begin
            n_miss++;
            $display("FAIL cset_in_wait: c=%h required %h", c, exp_c);
        end
    endtask

    task automatic test_reset_midload();
        for (int k = 0; k < NW; k++) pay[k] = DW'($urandom);
        pulse_start();
        for (int k = 0; k < 4; k++) send_word(pay[k], 0);
        rst = 1'b0;
        #1;
        exp_c = '0;
        n_vec++;
        if (c !== exp_c || loaded !== 1'b0 || cfg_ready !== 1'b0 || err !== 1'b0) begin
            n_miss++;
            $display("FAIL midload_reset: c=%h loaded=%b rdy=%b err=%b required 0", c, loaded, cfg_ready, err);
        end
        @(negedge clk);
        rst = 1'b1;
        cfg_valid = 1'b1;
        cfg_data = 8'h5A;
        pulse_cset();
        pulse_cset();
        cfg_valid = 1'b0;
        n_vec++;
        if (c !== exp_c || loaded !== 1'b0 || cfg_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL post_reset_idle: c=%h loaded=%b rdy=%b required 0 0 0", c, loaded, cfg_ready);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            bit bad;
            bit abort;
            int stall;
            logic [DW-1:0] chk;
            bad   = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 4) == 0);
            stall = $urandom_range(0, 2);
            if (abort) begin
                for (int k = 0; k < NW; k++) pay[k] = DW'($urandom);
                pulse_start();
                for (int k = 0; k < int'($urandom_range(1, NW)); k++) send_word(pay[k], 0);
            end
            for (int k = 0; k < NW; k++) pay[k] = DW'($urandom);
            chk = sum_of();
            if (bad) chk = chk ^ DW'($urandom_range(1, 255));
            pulse_start();
            n_vec++;
            if (loaded !== 1'b0 || err !== 1'b0) begin
                n_miss++;
                $display("FAIL rand_start it=%0d: loaded=%b err=%b required 0 0", it, loaded, err);
            end
            send_payload(chk, stall);
            n_vec++;
            if (loaded !== !bad || err !== bad || c !== exp_c) begin
                n_miss++;
                $display("FAIL rand_end it=%0d: loaded=%b err=%b c=%h required %b %b %h", it, loaded, err, c, !bad, bad, exp_c);
            end
            if ($urandom_range(0, 3) != 0) begin
                pulse_cset();
                if (!bad) exp_c = image_of();
                ref_c = exp_c;
                n_vec++;
                if (c !== ref_c || loaded !== 1'b0) begin
                    n_miss++;
                    $display("FAIL rand_commit it=%0d: c=%h loaded=%b required %h 0", it, c, loaded, ref_c);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_bad_checksum();
        test_abort();
        test_stalled();
        test_cset_outside_wait();
        test_reset_midload();
        test_random();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
